divu_p6y3: RTL and testbench

- Sequential unsigned restoring divider and the inverse companion of the 3x3 unsigned multiplier.
- Takes a P_WIDTH-bit dividend (the multiplier's product width) and a Y_WIDTH-bit divisor.
- Produces a P_WIDTH-bit quotient and a Y_WIDTH-bit remainder, one quotient bit per clock.
- Uses a start/rdy/done handshake so it can sit beside the multiplier in the same datapath.

---
 rtl/divu_p6y3.sv | 113 +++++++++++
 tb/tb_divu_p6y3.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_p6y3.sv
// Sequential unsigned restoring divider, companion to the 3x3 multiplier.
// Divides a P_WIDTH-bit dividend by a Y_WIDTH-bit divisor and produces one
// quotient bit per clock, MSB first. The start/rdy/done handshake matches the
// multiplier so both units can share a datapath.
module divu_p6y3 #(
  parameter int P_WIDTH = 6,
  parameter int Y_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] q,
  output logic [Y_WIDTH-1:0] r,
  output logic               rdy,
  output logic               done,
  output logic               dz
);

  localparam int CW = $clog2(P_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(P_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after P_WIDTH steps this one register holds the complete quotient.
  logic [P_WIDTH-1:0] dvd;
  logic [Y_WIDTH-1:0] dvs;
  // R < y holds after every step, so R's top bit is always zero and only the
  // low Y_WIDTH bits are stored.
  logic [Y_WIDTH-1:0] rem;
  logic [CW-1:0]      cnt;

  logic [Y_WIDTH:0]   t;
  logic [Y_WIDTH-1:0] diff;
  logic [Y_WIDTH-1:0] rem_nxt;
  logic               qbit;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  // The true difference is below y, so a Y_WIDTH-bit modular subtract is exact.
  always_comb begin
    t       = {rem, dvd[P_WIDTH-1]};
    qbit    = (t >= {1'b0, dvs});
    diff    = t[Y_WIDTH-1:0] - dvs;
    rem_nxt = qbit ? diff : t[Y_WIDTH-1:0];
  end

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      done  <= 1'b0;
      rdy   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd <= p;
            dvs <= y;
            rem <= '0;
            cnt <= CNT_LOAD;
            if (y == '0) begin
              state <= S_DONE;
              q     <= '1;
              r     <= '0;
              dz    <= 1'b1;
              done  <= 1'b1;
              rdy   <= 1'b1;
            end else begin
              state <= S_BUSY;
              rdy   <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            rdy   <= 1'b1;
          end
        end
        S_BUSY: begin
          dvd <= {dvd[P_WIDTH-2:0], qbit};
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            q     <= {dvd[P_WIDTH-2:0], qbit};
            r     <= rem_nxt;
            dz    <= 1'b0;
            done  <= 1'b1;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divu_p6y3.sv
// Self-checking bench for divu_p6y3 with a queue-based scoreboard.
module tb_divu_p6y3;

  localparam int PW = 6;
  localparam int YW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] p;
  logic [YW-1:0] y;
  logic [PW-1:0] q;
  logic [YW-1:0] r;
  logic          rdy;
  logic          done;
  logic          dz;

  always #5 clk = ~clk;

  divu_p6y3 #(.P_WIDTH(PW), .Y_WIDTH(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p(p), .y(y),
    .q(q), .r(r), .rdy(rdy), .done(done), .dz(dz)
  );

  typedef struct packed {
    logic [PW-1:0] q;
    logic [YW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference result: plain integer division, all-ones quotient on y == 0.
  function automatic exp_t model(int pv, int yv);
    exp_t e;
    if (yv == 0) begin
      e.q  = '1;
      e.r  = '0;
      e.dz = 1'b1;
    end else begin
      e.q  = PW'(pv / yv);
      e.r  = YW'(pv % yv);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive one start pulse; returns at the negedge right after the accept edge.
  task automatic start_op(input int pv, input int yv);
    @(negedge clk);
    p     = PW'(pv);
    y     = YW'(yv);
    start = 1'b1;
    sb.push_back(model(pv, yv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts edges after the accept edge.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (lat <= 20) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic exp_t pop_exp();
    if (sb.size() > 0) return sb.pop_front();
    return '1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    p     = '0;
    y     = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({q, r, dz, done, rdy} !== {6'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got q=%0d r=%0d dz=%b done=%b rdy=%b, want q=0 r=0 dz=0 done=0 rdy=1",
               q, r, dz, done, rdy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    start_op(45, 6);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rdy !== 1'b0 || done !== 1'b0 || q !== '0) begin
        bad++;
        $display("FAIL basic_busy[%0d]: got rdy=%b done=%b q=%0d, want rdy=0 done=0 q=0",
                 i, rdy, done, q);
      end
      @(negedge clk);
    end
    e = pop_exp();
    total++;
    if (done !== 1'b1 || rdy !== 1'b1 || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL basic_result: got done=%b rdy=%b q=%0d r=%0d dz=%b, want done=1 rdy=1 q=%0d r=%0d dz=%b",
               done, rdy, q, r, dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || rdy !== 1'b1 || q !== 6'd7 || r !== 3'd3) begin
      bad++;
      $display("FAIL basic_hold: got done=%b rdy=%b q=%0d r=%0d, want done=0 rdy=1 q=7 r=3",
               done, rdy, q, r);
    end
  endtask

  task automatic test_divisors();
    int   tp[3] = '{63, 63, 5};
    int   ty[3] = '{7, 1, 7};
    int   lat;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      start_op(tp[i], ty[i]);
      wait_done(lat, seen);
      e = pop_exp();
      total++;
      if (!seen || lat != 6 || {q, r, dz} !== e) begin
        bad++;
        $display("FAIL divisors[%0d]: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=6 q=%0d r=%0d dz=%b",
                 i, seen, lat, q, r, dz, e.q, e.r, e.dz);
      end
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    bit   seen;
    exp_t e;
    start_op(20, 0);
    wait_done(lat, seen);
    e = pop_exp();
    total++;
    if (!seen || lat != 0 || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL div_zero: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=0 q=%0d r=%0d dz=%b",
               seen, lat, q, r, dz, e.q, e.r, e.dz);
    end
    start_op(20, 3);
    total++;
    if (dz !== 1'b1 || q !== 6'd63) begin
      bad++;
      $display("FAIL div_zero_hold: got dz=%b q=%0d, want dz=1 q=63", dz, q);
    end
    wait_done(lat, seen);
    e = pop_exp();
    total++;
    if (!seen || lat != 6 || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL div_zero_clear: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=6 q=%0d r=%0d dz=%b",
               seen, lat, q, r, dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_busy();
    int   pulses = 0;
    exp_t g = '0;
    exp_t e;
    start_op(50, 5);
    p     = 6'd1;
    y     = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p     = '0;
    y     = '0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) begin
        pulses++;
        g = {q, r, dz};
      end
      @(negedge clk);
    end
    e = pop_exp();
    total++;
    if (pulses != 1 || g !== e) begin
      bad++;
      $display("FAIL busy_ignore: got pulses=%0d q=%0d r=%0d dz=%b, want pulses=1 q=%0d r=%0d dz=%b",
               pulses, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    bit   seen;
    exp_t e;
    start_op(45, 6);
    wait_done(lat, seen);
    e = pop_exp();
    total++;
    if (!seen || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL b2b_first: got seen=%b q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
               seen, q, r, dz, e.q, e.r, e.dz);
    end
    p     = 6'd44;
    y     = 3'd7;
    start = 1'b1;
    sb.push_back(model(44, 7));
    @(negedge clk);
    start = 1'b0;
    total++;
    if (rdy !== 1'b0 || q !== 6'd7 || r !== 3'd3) begin
      bad++;
      $display("FAIL b2b_accept: got rdy=%b q=%0d r=%0d, want rdy=0 q=7 r=3", rdy, q, r);
    end
    wait_done(lat, seen);
    e = pop_exp();
    total++;
    if (!seen || lat != 6 || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL b2b_second: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=6 q=%0d r=%0d dz=%b",
               seen, lat, q, r, dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    bit   seen;
    int   pulses = 0;
    exp_t e;
    start_op(60, 4);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    total++;
    if (q !== '0 || r !== '0 || rdy !== 1'b1 || done !== 1'b0 || dz !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got q=%0d r=%0d rdy=%b done=%b dz=%b, want q=0 r=0 rdy=1 done=0 dz=0",
               q, r, rdy, done, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_mid_nodone: got pulses=%0d, want 0", pulses);
    end
    start_op(60, 4);
    wait_done(lat, seen);
    e = pop_exp();
    total++;
    if (!seen || lat != 6 || {q, r, dz} !== e) begin
      bad++;
      $display("FAIL reset_mid_fresh: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=6 q=%0d r=%0d dz=%b",
               seen, lat, q, r, dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_sweep();
    int   lat;
    bit   seen;
    int   want_lat;
    exp_t e;
    for (int pv = 0; pv < 64; pv++) begin
      for (int yv = 0; yv < 8; yv++) begin
        start_op(pv, yv);
        wait_done(lat, seen);
        e        = pop_exp();
        want_lat = (yv == 0) ? 0 : 6;
        total++;
        if (!seen || lat != want_lat || {q, r, dz} !== e) begin
          bad++;
          $display("FAIL sweep p=%0d y=%0d: got seen=%b lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=%0d r=%0d dz=%b",
                   pv, yv, seen, lat, q, r, dz, want_lat, e.q, e.r, e.dz);
        end
        if (yv != 0) begin
          total++;
          if (int'(q) * yv + int'(r) != pv || int'(r) >= yv) begin
            bad++;
            $display("FAIL sweep_eq p=%0d y=%0d: got q*y+r=%0d r=%0d, want %0d with r<%0d",
                     pv, yv, int'(q) * yv + int'(r), r, pv, yv);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_divisors();
    test_div_zero();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
